// File: rtl/cbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cbus_arbiter (plus cbus_pkg bus types)
// Brief    : Burst-locked arbiter sharing one cache-bus port to memory
//            between several cache-side masters (ICache at index 0).
//            Round-robin or fixed-priority selection; the grant is held
//            until the memory side returns a beat with ready and last.
// Revision : 1.0 - initial release
// ============================================================================

package cbus_pkg;

  // Burst length, encoded as log2 of the beat count.
  typedef enum logic [2:0] {
    MLEN1  = 3'd0,
    MLEN2  = 3'd1,
    MLEN4  = 3'd2,
    MLEN8  = 3'd3,
    MLEN16 = 3'd4
  } cbus_len_t;

  // Master-to-memory request.
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] addr;
    logic [2:0]  size;
    cbus_len_t   len;
    logic [3:0]  strobe;
    logic [31:0] data;
  } cbus_req_t;

  // Memory-to-master response, one beat per ready.
  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int FIXED_PRIO = 0
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  cbus_req_t                  ireqs  [NUM_REQ],
  output cbus_resp_t                 oresps [NUM_REQ],
  output cbus_req_t                  oreq,
  input  cbus_resp_t                 iresp,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int c_idx_w = $clog2(NUM_REQ);
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_REQ - 1);
  localparam logic [c_idx_w:0]   c_num_ext  = (c_idx_w + 1)'(NUM_REQ);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t               r_state;
  logic [c_idx_w-1:0]   r_grant_idx;
  logic [c_idx_w-1:0]   r_rr_ptr;
  logic                 r_busy;

  // Scan order: slot k of the scan looks at requester w_scan_idx[k].
  logic [c_idx_w-1:0]   w_scan_idx [NUM_REQ];
  logic [NUM_REQ-1:0]   w_scan_vld;
  logic                 w_found;
  logic [c_idx_w-1:0]   w_cand;
  logic [c_idx_w-1:0]   w_cand_nxt;
  logic                 w_release;
  logic [NUM_REQ-1:0]   w_port_hit;

  // In round-robin mode the scan starts at rr_ptr and wraps modulo NUM_REQ;
  // in fixed-priority mode it is simply 0, 1, 2, ... so index 0 always wins.
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_scan
    logic [c_idx_w:0] w_sum;

    assign w_sum = {1'b0, r_rr_ptr} + (c_idx_w + 1)'(k);

    assign w_scan_idx[k] = (FIXED_PRIO != 0)   ? c_idx_w'(k) :
                           (w_sum >= c_num_ext) ? c_idx_w'(w_sum - c_num_ext) :
                                                  w_sum[c_idx_w-1:0];

    assign w_scan_vld[k] = ireqs[w_scan_idx[k]].valid;
  end

  // Pick the first valid requester in scan order.
  always_comb begin
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && w_scan_vld[k]) begin
        w_found = 1'b1;
        w_cand  = w_scan_idx[k];
      end
    end
  end

  // The requester after the winner becomes the new highest priority.
  assign w_cand_nxt = (w_cand == c_last_idx) ? '0 : w_cand + 1'b1;

  // A burst ends only on a beat carrying both ready and last.
  assign w_release = iresp.ready && iresp.last;

  // Grant/release state machine; selection is only sampled at the clock edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_grant_idx <= '0;
      r_rr_ptr    <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state     <= BUSY;
            r_busy      <= 1'b1;
            r_grant_idx <= w_cand;
            if (FIXED_PRIO == 0) begin
              r_rr_ptr <= w_cand_nxt;
            end
          end
        end
        BUSY: begin
          if (w_release) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Forward the granted master's request unchanged; drive zeros while idle.
  always_comb begin
    oreq = '0;
    if (r_state == BUSY) begin
      oreq = ireqs[r_grant_idx];
    end
  end

  // Only the granted master ever sees the memory response.
  for (genvar j = 0; j < NUM_REQ; j++) begin : g_resp
    assign w_port_hit[j] = (r_state == BUSY) && (r_grant_idx == c_idx_w'(j));
    assign oresps[j]     = w_port_hit[j] ? iresp : cbus_resp_t'('0);
  end

  assign busy      = r_busy;
  assign grant_idx = r_grant_idx;

endmodule

`default_nettype wire

// File: tb/tb_cbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cbus_arbiter
// Brief    : Randomized self-checking bench for cbus_arbiter. Three DUTs
//            (2-port round-robin, 2-port fixed priority, 3-port round-robin)
//            run side by side, each against a simple ownership model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cbus_arbiter;
  import cbus_pkg::*;

  localparam int NCFG         = 3;
  localparam int PHASE_CYCLES = 700;

  logic clk;
  logic resetn;
  int   n_checks;
  int   n_fail;
  int   p_req;
  int   p_ready;
  event ev_rst_chk;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs,
                          input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic cbus_req_t rand_req();
    cbus_req_t r;
    r.valid    = 1'b1;
    r.is_write = 1'($urandom_range(0, 1));
    r.addr     = $urandom;
    r.size     = 3'($urandom_range(0, 2));
    r.len      = cbus_len_t'(3'($urandom_range(0, 4)));
    r.strobe   = 4'($urandom);
    r.data     = $urandom;
    return r;
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int N  = (g == 2) ? 3 : 2;
    localparam int FP = (g == 1) ? 1 : 0;
    localparam int IW = $clog2(N);

    cbus_req_t      reqs  [N];
    cbus_resp_t     resps [N];
    cbus_req_t      mreq;
    cbus_resp_t     mresp;
    logic           bsy;
    logic [IW-1:0]  gidx;

    // Model: owner = master holding the bus (-1 none), start = first index
    // looked at in the next round-robin arbitration.
    int   owner = -1;
    int   start = 0;
    int   beat  = 0;
    logic done [N] = '{default: 1'b0};

    cbus_arbiter #(
      .NUM_REQ    (N),
      .FIXED_PRIO (FP)
    ) u_dut (
      .clk       (clk),
      .resetn    (resetn),
      .ireqs     (reqs),
      .oresps    (resps),
      .oreq      (mreq),
      .iresp     (mresp),
      .busy      (bsy),
      .grant_idx (gidx)
    );

    // Masters and memory: masters hold a request until they see last, then
    // drop valid for at least one cycle; memory counts beats per burst.
    initial begin
      for (int j = 0; j < N; j++) reqs[j] = '0;
      mresp = '0;
      forever begin
        @(posedge clk);
        #1;
        for (int j = 0; j < N; j++) begin
          if (resetn) begin
            if (done[j]) begin
              reqs[j] = '0;
            end else if (!reqs[j].valid &&
                         (int'($urandom_range(0, 99)) < p_req)) begin
              reqs[j] = rand_req();
            end
          end
        end
        #1;
        mresp.data = $urandom;
        if (resetn && mreq.valid && (int'($urandom_range(0, 99)) < p_ready)) begin
          mresp.ready = 1'b1;
          mresp.last  = (beat == (1 << int'(mreq.len)) - 1);
        end else begin
          mresp.ready = 1'b0;
          mresp.last  = 1'b0;
        end
      end
    end

    // Compare DUT outputs with the model, then advance the model one cycle.
    always @(negedge clk) begin
      cbus_resp_t exp_r;
      int         idx;
      if (!resetn) begin
        owner = -1;
        start = 0;
        beat  = 0;
        for (int j = 0; j < N; j++) done[j] = 1'b0;
      end else begin
        check_eq($sformatf("cfg%0d busy", g), bsy, owner >= 0);
        if (owner >= 0) begin
          check_eq($sformatf("cfg%0d grant_idx", g), gidx, owner);
          check_eq($sformatf("cfg%0d oreq", g), mreq, reqs[owner]);
        end else begin
          check_eq($sformatf("cfg%0d oreq idle", g), mreq, '0);
        end
        for (int j = 0; j < N; j++) begin
          exp_r = '0;
          if (j == owner) exp_r = mresp;
          check_eq($sformatf("cfg%0d oresps[%0d]", g, j), resps[j], exp_r);
          done[j] = resps[j].ready && resps[j].last;
        end

        if (mreq.valid && mresp.ready) begin
          beat = mresp.last ? 0 : beat + 1;
        end

        if (owner < 0) begin
          for (int k = 0; k < N; k++) begin
            idx = (FP != 0) ? k : (start + k) % N;
            if (reqs[idx].valid) begin
              owner = idx;
              if (FP == 0) start = (idx + 1) % N;
              break;
            end
          end
        end else if (mresp.ready && mresp.last) begin
          owner = -1;
        end
      end
    end

    // Outputs must collapse to idle as soon as reset is asserted.
    always @(ev_rst_chk) begin
      check_eq($sformatf("cfg%0d busy in reset", g), bsy, 1'b0);
      check_eq($sformatf("cfg%0d oreq in reset", g), mreq, '0);
      for (int j = 0; j < N; j++) begin
        check_eq($sformatf("cfg%0d oresps[%0d] in reset", g, j), resps[j], '0);
      end
    end
  end

  // Sequencer: traffic phases, each ended by an asynchronous reset between edges.
  initial begin
    n_checks = 0;
    n_fail   = 0;
    p_req    = 50;
    p_ready  = 50;
    resetn   = 1'b0;
    repeat (3) @(posedge clk);
    #2 -> ev_rst_chk;
    @(posedge clk);
    #3 resetn = 1'b1;

    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0:       begin p_req = 100; p_ready = 100; end
        1:       begin p_req = 100; p_ready = 25;  end
        2:       begin p_req = 40;  p_ready = 60;  end
        default: begin p_req = 15;  p_ready = 90;  end
      endcase
      repeat (PHASE_CYCLES) @(posedge clk);
      #3 resetn = 1'b0;
      #1 -> ev_rst_chk;
      @(posedge clk);
      #3 resetn = 1'b1;
    end

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
